// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: per-stage bundle widths,
// ID/EX control-field layout and small helpers.
package pipe_pkg;

    localparam int unsigned IDEX_CTRL_W  = 7;
    localparam int unsigned IDEX_DATA_W  = 121;
    localparam int unsigned EXMEM_CTRL_W = 4;
    localparam int unsigned EXMEM_DATA_W = 69;
    localparam int unsigned MEMWB_CTRL_W = 2;
    localparam int unsigned MEMWB_DATA_W = 69;

    localparam int unsigned ALUOP_LSB    = 5;
    localparam int unsigned ALUSRC_BIT   = 4;
    localparam int unsigned REGWRITE_BIT = 3;
    localparam int unsigned MEMTOREG_BIT = 2;
    localparam int unsigned MEMREAD_BIT  = 1;
    localparam int unsigned MEMWRITE_BIT = 0;

    localparam logic [IDEX_CTRL_W-1:0] NOP_CTRL = '0;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
    } idex_ctrl_t;

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } occ_e;

    function automatic logic [1:0] occ_count(input logic m_valid, input logic s_valid);
        return {1'b0, m_valid} + {1'b0, s_valid};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake carrying a control bundle and a data bundle.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = IDEX_CTRL_W,
    parameter int unsigned DATA_W = IDEX_DATA_W
) ();

    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/pipe_slot.sv
// One pipeline slot: valid + ctrl + data. Clear wins over load and keeps data,
// so an empty slot always presents a zero control bundle.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = IDEX_CTRL_W,
    parameter int unsigned DATA_W = IDEX_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_d, valid_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [DATA_W-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer, flush, bubble
// insertion and freeze. Slot M drives the outputs, slot S absorbs one overflow.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = IDEX_CTRL_W,
    parameter int unsigned DATA_W = IDEX_DATA_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     flush_i,
    input  logic                     bubble_i,
    pipe_stage_skid_if.slave         up_if,
    pipe_stage_skid_if.master        dn_if,
    output logic [1:0]               occupancy_o
);

    logic              m_valid, s_valid;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, entry_ctrl, m_ctrl_in;
    logic [DATA_W-1:0] m_data, s_data, m_data_in;
    logic              acc, drn;
    logic              m_load, m_clear, s_load, s_clear;

    // in_ready depends only on registered state, never on downstream ready.
    assign up_if.ready = start_i & ~s_valid;
    assign dn_if.valid = start_i & m_valid;
    assign dn_if.ctrl  = m_ctrl;
    assign dn_if.data  = m_data;

    always_comb begin
        acc        = up_if.valid & up_if.ready & ~flush_i;
        drn        = dn_if.valid & dn_if.ready & ~flush_i;
        entry_ctrl = bubble_i ? '0 : up_if.ctrl;

        // S only ever refills M, and acc cannot coincide with a valid S.
        m_ctrl_in  = s_valid ? s_ctrl : entry_ctrl;
        m_data_in  = s_valid ? s_data : up_if.data;

        m_load     = (drn & s_valid) | (acc & (~m_valid | drn));
        m_clear    = flush_i | (drn & ~s_valid & ~acc);
        s_load     = acc & m_valid & ~drn;
        s_clear    = flush_i | (drn & s_valid);
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_slot_m (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (m_clear),
        .load_i  (m_load),
        .ctrl_i  (m_ctrl_in),
        .data_i  (m_data_in),
        .valid_o (m_valid),
        .ctrl_o  (m_ctrl),
        .data_o  (m_data)
    );

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_slot_s (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (s_clear),
        .load_i  (s_load),
        .ctrl_i  (entry_ctrl),
        .data_i  (up_if.data),
        .valid_o (s_valid),
        .ctrl_o  (s_ctrl),
        .data_o  (s_data)
    );

    assign occupancy_o = occ_count(m_valid, s_valid);

    occ_legal_a : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (occupancy_o != 2'd3) && (!s_valid || m_valid));

endmodule
